cpu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 8-bit processor.
- Steps each instruction through fetch, decode, execute/memory/IO and write-back.
- Consumes the decoded control word (J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ) and the ALU compare flag.
- Drives the write-enables and selects for the IR, PC, register bank, data memory and I/O port. Sits between the control unit and the stage registers.

---
 rtl/cpu_seq_pkg.sv | 26 ++
 rtl/cpu_sequencer_wait.sv | 16 +
 rtl/cpu_sequencer.sv | 84 ++++++++
 tb/tb_cpu_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encodings, control-word bit indices and write-back source codes for the sequencer.
package cpu_seq_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IO_IN  = 3'd5,
    S_IO_OUT = 3'd6,
    S_HALT   = 3'd7
  } state_t;
  localparam int CTRL_J    = 8;
  localparam int CTRL_JC   = 7;
  localparam int CTRL_INA  = 6;
  localparam int CTRL_RM   = 5;
  localparam int CTRL_WM   = 4;
  localparam int CTRL_SIN  = 3;
  localparam int CTRL_SOUT = 2;
  localparam int CTRL_WR   = 1;
  localparam int CTRL_NEQ  = 0;
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_IN  = 2'b10;
  localparam int CNT_W = 4;
endpackage

// File: rtl/cpu_sequencer_wait.sv
// seq_wait_counter: loadable down-counter that flags its final cycle; times the data-memory access.
module seq_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  assign last_o = cnt_q == '0;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/write-back sequencer driving the stage-register enables.
// Define CPU_SINGLE_STEP_EN to add the step input and park in HALT after every commit.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
`ifdef CPU_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [8:0] ctrl,
  input  logic       cmp_eq,
  input  logic       in_valid,
  output logic       in_ack,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       mem_re,
  output logic       mem_we,
  output logic       rf_we,
  output logic [1:0] rf_src,
  output logic [2:0] state,
  output logic       instr_done
);
  state_t state_q, state_d, done_st;
  logic act, rm, wm, tk, last, commit, unused_ina;
`ifdef CPU_SINGLE_STEP_EN
  assign done_st = S_HALT;
`else
  assign done_st = S_FETCH;
`endif
  assign act = ~reset;
  assign rm = ctrl[CTRL_RM];
  assign wm = ctrl[CTRL_WM] & ~rm;
  assign tk = ctrl[CTRL_J] | (ctrl[CTRL_JC] & (cmp_eq ^ ctrl[CTRL_NEQ]));
  assign unused_ina = ctrl[CTRL_INA];
  seq_wait_counter #(.W(CNT_W)) u_wait (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (state_q == S_DECODE),
    .load_val_i (CNT_W'(MEM_LAT - 1)),
    .dec_i      (state_q == S_MEM),
    .last_o     (last)
  );
  always_ff @(posedge clock) state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = ctrl[CTRL_SIN] ? S_IO_IN : ctrl[CTRL_SOUT] ? S_IO_OUT :
                          (rm | wm) ? S_MEM : S_EXEC;
      S_EXEC:   state_d = done_st;
      S_MEM:    state_d = !last ? S_MEM : rm ? S_WB : done_st;
      S_WB:     state_d = done_st;
      S_IO_IN:  state_d = in_valid ? done_st : S_IO_IN;
      S_IO_OUT: state_d = out_ready ? done_st : S_IO_OUT;
`ifdef CPU_SINGLE_STEP_EN
      S_HALT:   state_d = step ? S_FETCH : S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end
  always_comb begin
    commit = act & ((state_q == S_EXEC) | (state_q == S_WB) |
                    (state_q == S_MEM & last & ~rm) |
                    (state_q == S_IO_IN & in_valid) |
                    (state_q == S_IO_OUT & out_ready));
    ir_we      = act & (state_q == S_FETCH);
    pc_we      = commit;
    pc_sel     = commit & tk;
    instr_done = commit;
    mem_re     = act & (state_q == S_MEM) & rm;
    mem_we     = act & (state_q == S_MEM) & wm;
    in_ack     = act & (state_q == S_IO_IN) & in_valid;
    out_valid  = act & (state_q == S_IO_OUT);
    rf_we      = act & ctrl[CTRL_WR] & ((state_q == S_EXEC) | (state_q == S_WB) | in_ack);
    rf_src     = in_ack ? SRC_IN : (act & state_q == S_WB) ? SRC_MEM : SRC_ALU;
    state      = act ? state_q : S_FETCH;
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed sequence with a commit scoreboard, MEM_LAT=3, default (no single-step) build.
module tb_cpu_sequencer;
  localparam logic [8:0] J = 9'h100, JC = 9'h080, RM = 9'h020, WM = 9'h010;
  localparam logic [8:0] SIN = 9'h008, SOUT = 9'h004, WR = 9'h002, NEQ = 9'h001;
  logic clock = 1'b0, reset, cmp_eq, in_valid, out_ready;
  logic [8:0] ctrl;
  logic in_ack, out_valid, ir_we, pc_we, pc_sel, mem_re, mem_we, rf_we, instr_done;
  logic [1:0] rf_src;
  logic [2:0] state;
  logic [3:0] exp_q[$];
  int n_assert = 0, n_fail = 0;

  cpu_sequencer #(.MEM_LAT(3)) dut (
    .clock(clock), .reset(reset), .ctrl(ctrl), .cmp_eq(cmp_eq),
    .in_valid(in_valid), .in_ack(in_ack), .out_valid(out_valid), .out_ready(out_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .mem_re(mem_re), .mem_we(mem_we),
    .rf_we(rf_we), .rf_src(rf_src), .state(state), .instr_done(instr_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {2'b00, state, in_ack, out_valid, ir_we, pc_we, pc_sel, mem_re, mem_we, rf_we, rf_src, instr_done};
  endfunction

  function automatic logic [15:0] exp_o(input logic [2:0] st, input logic ia, ov, ir, pw, ps, mr, mw, rw,
                                        input logic [1:0] rs);
    return {2'b00, st, ia, ov, ir, pw, ps, mr, mw, rw, rs, pw};
  endfunction

  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  // Every commit must match the oldest pending expectation {pc_sel, rf_we, rf_src}.
  always @(negedge clock) begin
    if (instr_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL commit_unexpected: observed commit with empty scoreboard");
      end else chk("commit", {12'd0, pc_sel, rf_we, rf_src}, {12'd0, exp_q.pop_front()});
    end
  end

  task automatic exec_instr(input string tag, input logic [8:0] c, input logic cmp, input logic ps, input logic rw);
    ctrl = c;
    cmp_eq = cmp;
    exp_q.push_back({ps, rw, 2'b00});
    tick();
    chk({tag, "_decode"}, obs(), exp_o(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    tick();
    chk({tag, "_exec"}, obs(), exp_o(3'd2, 0, 0, 0, 1, ps, 0, 0, rw, 2'b00));
    tick();
    chk({tag, "_fetch"}, obs(), exp_o(3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
  endtask

  task automatic mem_instr(input string tag, input logic [8:0] c, input logic rd, input logic rw);
    ctrl = c;
    cmp_eq = 1'b0;
    exp_q.push_back({1'b0, rd & rw, rd ? 2'b01 : 2'b00});
    tick();
    chk({tag, "_decode"}, obs(), exp_o(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_mem"}, obs(), exp_o(3'd3, 0, 0, 0, !rd && i == 2, 0, rd, !rd, 0, 2'b00));
    end
    if (rd) begin
      tick();
      chk({tag, "_wb"}, obs(), exp_o(3'd4, 0, 0, 0, 1, 0, 0, 0, rw, 2'b01));
    end
    tick();
    chk({tag, "_fetch"}, obs(), exp_o(3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
  endtask

  initial begin
    reset = 1'b1; ctrl = '0; cmp_eq = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset", obs(), exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    reset = 1'b0;
    #1;
    chk("fetch0", obs(), exp_o(3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
    exec_instr("nop", 9'h000, 1'b0, 1'b0, 1'b0);
    exec_instr("jc_ne_taken", JC | NEQ, 1'b0, 1'b1, 1'b0);
    exec_instr("jc_ne_not", JC | NEQ, 1'b1, 1'b0, 1'b0);
    exec_instr("jc_eq_taken", JC | WR, 1'b1, 1'b1, 1'b1);
    exec_instr("j_cmp0", J, 1'b0, 1'b1, 1'b0);
    exec_instr("j_cmp1", J | NEQ, 1'b1, 1'b1, 1'b0);
    mem_instr("rd", RM | WR, 1'b1, 1'b1);
    mem_instr("wr", WM | WR, 1'b0, 1'b0);
    mem_instr("rdwm", RM | WM, 1'b1, 1'b0);
    // Input port: 5 idle cycles, then handshake
    ctrl = SIN | WR;
    exp_q.push_back(4'b0110);
    tick();
    chk("in_decode", obs(), exp_o(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("in_wait", obs(), exp_o(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    end
    tick();
    in_valid = 1'b1;
    #1;
    chk("in_take", obs(), exp_o(3'd5, 1, 0, 0, 1, 0, 0, 0, 1, 2'b10));
    tick();
    chk("in_fetch_noack", obs(), exp_o(3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
    in_valid = 1'b0;
    // Output port: 4 stalled cycles, then accept
    ctrl = SOUT;
    exp_q.push_back(4'b0000);
    tick();
    chk("out_decode", obs(), exp_o(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("out_wait", obs(), exp_o(3'd6, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
    end
    tick();
    out_ready = 1'b1;
    #1;
    chk("out_take", obs(), exp_o(3'd6, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00));
    tick();
    chk("out_fetch", obs(), exp_o(3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
    out_ready = 1'b0;
    // Output stalled, then reset abandons the instruction
    tick();
    tick();
    chk("out2_wait", obs(), exp_o(3'd6, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("reset_mid", obs(), exp_o(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    ctrl = '0;
    #1;
    chk("after_reset", obs(), exp_o(3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
    exec_instr("post_reset", WR, 1'b0, 1'b0, 1'b1);
    tick();
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
